// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle for the sequential divider.
interface seq_divider_if #(
    parameter int unsigned WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 signed_op;
    logic [2*WIDTH-1:0]   dividend;
    logic [WIDTH-1:0]     divisor;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     quotient;
    logic [WIDTH-1:0]     remainder;
    logic                 error_divide_by_zero;
    logic                 overflow;

    modport master (
        output in_valid, signed_op, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, error_divide_by_zero, overflow
    );

    modport slave (
        input  in_valid, signed_op, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, error_divide_by_zero, overflow
    );
endinterface

// File: rtl/seq_divider.sv
// Iterative non-restoring divider: 2*WIDTH / WIDTH -> WIDTH quotient and remainder.
module seq_divider #(
    parameter int unsigned ARCH           = 0,
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned GRP_WIDTH      = 4,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_divider_if.slave  bus
);
    localparam int unsigned W     = WIDTH;
    localparam int unsigned RW    = WIDTH + 2;   // signed partial remainder, holds +-2*divisor
    localparam int unsigned STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CW    = $clog2(STEPS + 1);
    localparam logic [W-1:0] Q_HALF = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   acc_q, acc_d;
    logic [W-1:0]    qr_q, qr_d;
    logic [W-1:0]    dvs_q, dvs_d;
    logic [W-1:0]    lo_q, lo_d;
    logic            sgn_q, sgn_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    quo_q, quo_d;
    logic [W-1:0]    rem_q, rem_d;
    logic            dbz_q, dbz_d;
    logic            ovf_q, ovf_d;

    logic            dvd_neg, dvs_neg, sub, ovf_chk;
    logic [2*W:0]    dvd_ext, dvd_mag;
    logic [W:0]      dvs_ext, dvs_mag;
    logic [RW-1:0]   calc_acc, calc_sh;
    logic [W-1:0]    calc_q, rem_mag;

    // One adder/subtracter row: a + b or a - b, ripple or carry-select.
    function automatic logic [RW-1:0] add_sub_row(input logic [RW-1:0] a,
                                                  input logic [RW-1:0] b,
                                                  input logic          do_sub);
        logic [RW-1:0] bx, s, s0, s1;
        logic          c, c0, c1;
        bx = b ^ {RW{do_sub}};
        s  = '0;
        s0 = '0;
        s1 = '0;
        c  = do_sub;
        if (ARCH == 0) begin
            s = a + bx + RW'(do_sub);
        end else begin
            for (int g = 0; g < int'(RW); g += int'(GRP_WIDTH)) begin
                c0 = 1'b0;
                c1 = 1'b1;
                for (int i = g; i < g + int'(GRP_WIDTH) && i < int'(RW); i++) begin
                    s0[i] = a[i] ^ bx[i] ^ c0;
                    c0    = (a[i] & bx[i]) | (c0 & (a[i] ^ bx[i]));
                    s1[i] = a[i] ^ bx[i] ^ c1;
                    c1    = (a[i] & bx[i]) | (c1 & (a[i] ^ bx[i]));
                end
                for (int i = g; i < g + int'(GRP_WIDTH) && i < int'(RW); i++) begin
                    s[i] = c ? s1[i] : s0[i];
                end
                c = c ? c1 : c0;
            end
        end
        return s;
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            qr_q        <= '0;
            dvs_q       <= '0;
            lo_q        <= '0;
            sgn_q       <= 1'b0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            quo_q       <= '0;
            rem_q       <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            qr_q        <= qr_d;
            dvs_q       <= dvs_d;
            lo_q        <= lo_d;
            sgn_q       <= sgn_d;
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
        end
    end

    // Next-state, iteration datapath and result formatting.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        qr_d    = qr_q;
        dvs_d   = dvs_q;
        lo_d    = lo_q;
        sgn_d   = sgn_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;

        // Operand magnitudes, one bit wider so the most-negative value does not wrap.
        dvd_neg = bus.signed_op & bus.dividend[2*W-1];
        dvs_neg = bus.signed_op & bus.divisor[W-1];
        dvd_ext = {dvd_neg, bus.dividend};
        dvs_ext = {dvs_neg, bus.divisor};
        dvd_mag = dvd_neg ? -dvd_ext : dvd_ext;
        dvs_mag = dvs_neg ? -dvs_ext : dvs_ext;

        // BITS_PER_CYCLE unrolled non-restoring steps, quotient MSB first.
        calc_acc = acc_q;
        calc_q   = qr_q;
        sub      = 1'b0;
        calc_sh  = '0;
        for (int k = 0; k < int'(BITS_PER_CYCLE); k++) begin
            sub       = ~calc_acc[RW-1];
            calc_sh   = {calc_acc[RW-2:0], calc_q[W-1]};
            calc_q    = {calc_q[W-2:0], 1'b0};
            calc_acc  = add_sub_row(calc_sh, {2'b00, dvs_q}, sub);
            calc_q[0] = ~calc_acc[RW-1];
        end

        rem_mag = acc_q[RW-1] ? W'(add_sub_row(acc_q, {2'b00, dvs_q}, 1'b0)) : acc_q[W-1:0];
        ovf_chk = sgn_q && (qr_q > (qneg_q ? Q_HALF : Q_HALF - W'(1)));

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    sgn_d  = bus.signed_op;
                    qneg_d = dvd_neg ^ dvs_neg;
                    rneg_d = dvd_neg;
                    lo_d   = bus.dividend[W-1:0];
                    dvs_d  = dvs_mag[W-1:0];
                    acc_d  = {2'b00, dvd_mag[2*W-1:W]};
                    qr_d   = dvd_mag[W-1:0];
                    cnt_d  = '0;
                    if (bus.divisor == '0) begin
                        state_d = DONE;
                        dbz_d   = 1'b1;
                        ovf_d   = 1'b0;
                        quo_d   = '1;
                        rem_d   = bus.dividend[W-1:0];
                    end else if (dvd_mag[2*W:W] >= dvs_mag) begin
                        state_d = DONE;
                        dbz_d   = 1'b0;
                        ovf_d   = 1'b1;
                        quo_d   = '1;
                        rem_d   = bus.dividend[W-1:0];
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                acc_d = calc_acc;
                qr_d  = calc_q;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(STEPS - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = DONE;
                dbz_d   = 1'b0;
                if (ovf_chk) begin
                    ovf_d = 1'b1;
                    quo_d = '1;
                    rem_d = lo_q;
                end else begin
                    ovf_d = 1'b0;
                    quo_d = qneg_q ? -qr_q : qr_q;
                    rem_d = rneg_q ? -rem_mag : rem_mag;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                    dbz_d   = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    assign bus.in_ready             = in_ready_q;
    assign bus.out_valid            = out_valid_q;
    assign bus.quotient             = quo_q;
    assign bus.remainder            = rem_q;
    assign bus.error_divide_by_zero = dbz_q;
    assign bus.overflow             = ovf_q;
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider at WIDTH=8, one quotient bit per cycle.
module tb_seq_divider;
    localparam int unsigned W = 8;

    typedef struct {
        logic [15:0] dvd;
        logic [7:0]  dvs;
        logic        sop;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        dz;
        logic        ov;
        int          lat;
        string       name;
    } vec_t;

    typedef struct {
        vec_t v;
        int   acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    logic ov_prev = 1'b0;
    exp_t sb[$];
    vec_t vecs[12];

    seq_divider_if #(.WIDTH(W)) bus();

    seq_divider #(
        .ARCH(0),
        .WIDTH(W),
        .GRP_WIDTH(4),
        .BITS_PER_CYCLE(1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pop and compare on each rising out_valid.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus.out_valid && !ov_prev) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_out_valid: got out_valid=1 q=%0h, expected none", bus.quotient);
            end else begin
                e = sb.pop_front();
                chk({e.v.name, "_quotient"}, bus.quotient, e.v.q);
                chk({e.v.name, "_remainder"}, bus.remainder, e.v.r);
                chk({e.v.name, "_dbz"}, bus.error_divide_by_zero, e.v.dz);
                chk({e.v.name, "_ovf"}, bus.overflow, e.v.ov);
                chk({e.v.name, "_latency"}, cyc - e.acc, e.v.lat);
            end
        end
        ov_prev = bus.out_valid;
    end

    // Present operands, wait for acceptance, scramble inputs afterwards.
    task automatic send(input vec_t v, input bit push);
        int n;
        @(negedge clk);
        bus.dividend  = v.dvd;
        bus.divisor   = v.dvs;
        bus.signed_op = v.sop;
        bus.in_valid  = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            chk({v.name, "_accept_timeout"}, bus.in_ready, 1);
            bus.in_valid = 1'b0;
            return;
        end
        if (push) sb.push_back('{v: v, acc: cyc});
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.signed_op = ~v.sop;
        bus.dividend  = ~v.dvd;
        bus.divisor   = 8'h00;
    endtask

    task automatic wait_valid(input string nm);
        int n;
        n = 0;
        while (!bus.out_valid && n < 200) begin
            chk({nm, "_busy_in_ready"}, bus.in_ready, 0);
            @(negedge clk);
            n++;
        end
        chk({nm, "_out_valid"}, bus.out_valid, 1);
        chk({nm, "_done_in_ready"}, bus.in_ready, 0);
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (bus.out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_idle_timeout"}, bus.out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v50;
        vecs = '{
            '{16'd1000, 8'd7,   1'b0, 8'd142, 8'd6,   1'b0, 1'b0, 10, "u_1000_7"},
            '{16'hFF9C, 8'd7,   1'b1, 8'hF2,  8'hFE,  1'b0, 1'b0, 10, "s_m100_7"},
            '{16'd100,  8'hF9,  1'b1, 8'hF2,  8'h02,  1'b0, 1'b0, 10, "s_100_m7"},
            '{16'h1234, 8'h00,  1'b0, 8'hFF,  8'h34,  1'b1, 1'b0, 1,  "u_dbz"},
            '{16'h0800, 8'h08,  1'b0, 8'hFF,  8'h00,  1'b0, 1'b1, 1,  "u_ovf_pre"},
            '{16'd128,  8'd1,   1'b1, 8'hFF,  8'h80,  1'b0, 1'b1, 10, "s_ovf_fix"},
            '{16'hFF80, 8'd1,   1'b1, 8'h80,  8'h00,  1'b0, 1'b0, 10, "s_m128_1"},
            '{16'hFF80, 8'h80,  1'b1, 8'h01,  8'h00,  1'b0, 1'b0, 10, "s_m128_m128"},
            '{16'hFFF2, 8'd7,   1'b1, 8'hFE,  8'h00,  1'b0, 1'b0, 10, "s_m14_7"},
            '{16'hFEFF, 8'hFF,  1'b0, 8'hFF,  8'hFE,  1'b0, 1'b0, 10, "u_max"},
            '{16'hFF00, 8'h00,  1'b1, 8'hFF,  8'h00,  1'b1, 1'b0, 1,  "s_dbz"},
            '{16'h8000, 8'd1,   1'b1, 8'hFF,  8'h00,  1'b0, 1'b1, 1,  "s_ovf_pre"}
        };
        v50 = '{16'd50, 8'd5, 1'b0, 8'd10, 8'd0, 1'b0, 1'b0, 10, "u_50_5"};

        bus.in_valid  = 1'b0;
        bus.signed_op = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b1;

        // Reset state
        #1;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_quotient", bus.quotient, 0);
        chk("rst_remainder", bus.remainder, 0);
        chk("rst_dbz", bus.error_divide_by_zero, 0);
        chk("rst_ovf", bus.overflow, 0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_held_in_ready", bus.in_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", bus.in_ready, 1);

        // Directed vectors, consumer always ready
        foreach (vecs[i]) begin
            send(vecs[i], 1'b1);
            wait_valid(vecs[i].name);
            wait_idle(vecs[i].name);
        end

        // Backpressure with a competing request held during the stall
        bus.out_ready = 1'b0;
        send(vecs[0], 1'b1);
        wait_valid("bp");
        bus.dividend  = v50.dvd;
        bus.divisor   = v50.dvs;
        bus.signed_op = v50.sop;
        bus.in_valid  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_quotient", bus.quotient, 8'd142);
            chk("bp_remainder", bus.remainder, 8'd6);
            chk("bp_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_out_valid", bus.out_valid, 0);
        chk("bp_release_in_ready", bus.in_ready, 1);
        sb.push_back('{v: v50, acc: cyc});
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_valid("bp_next");
        wait_idle("bp_next");

        // Asynchronous reset in the middle of CALC
        send(vecs[0], 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", bus.in_ready, 0);
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_quotient", bus.quotient, 0);
        chk("mid_rst_remainder", bus.remainder, 0);
        chk("mid_rst_flags", {bus.error_divide_by_zero, bus.overflow}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_release_in_ready", bus.in_ready, 1);
        send(v50, 1'b1);
        wait_valid("after_rst");
        wait_idle("after_rst");

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
